prog_pattern_det: RTL and testbench
===================================

PROG_PATTERN_DET -- requirements
Module: prog_pattern_det

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (legal 2..32).
REQ-002 Parameter OVERLAP, default 1, selects detection mode: 1 = overlapping matches, 0 = non-overlapping matches.
REQ-003 Parameter CNT_W, default 16, hit counter width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous assertion, active-low.
REQ-006 load  input  1  captures pat_in and len_in at the rising edge.
REQ-007 pat_in  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] is the last.
REQ-008 len_in  input  $clog2(MAX_LEN+1)  pattern length in bits.
REQ-009 in_valid  input  1  qualifies in_bit.
REQ-010 in_bit  input  1  serial data bit.
REQ-011 p_det  output  1  registered one-cycle detection pulse.
REQ-012 armed  output  1  high while a legal pattern is loaded.
REQ-013 hit_cnt  output  CNT_W  saturating detection count; present only under the configuration macro.

Function
REQ-014 The FSM SHALL have exactly two states: UNCONF (armed=0) and ARMED (armed=1).
REQ-015 On load=1 with 1<=len_in<=MAX_LEN, the block SHALL capture the pattern and length, clear the history and fill count, and enter ARMED.
REQ-016 On load=1 with len_in=0 or len_in>MAX_LEN, the block SHALL enter UNCONF and clear the history and fill count.
REQ-017 When load=1, the block SHALL ignore in_valid/in_bit on that edge and SHALL NOT assert p_det on the following cycle.
REQ-018 In ARMED with in_valid=1, the block SHALL shift in_bit into the history LSB and increment the fill count, saturating at MAX_LEN.
REQ-019 When in_valid=0, the block SHALL hold the history and fill count, and p_det SHALL be 0 on the next cycle.
REQ-020 A match SHALL be declared when the updated history[len-1:0] equals pat[len-1:0] and the updated fill count is >= len.
REQ-021 On a match, p_det SHALL be 1 for exactly the cycle after the sampling edge; latency is 1 clock.
REQ-022 With OVERLAP=1, the history and fill count SHALL be kept after a match.
REQ-023 With OVERLAP=0, the fill count SHALL clear to 0 on a match, so no bit is shared between matches.
REQ-024 In UNCONF, the block SHALL ignore input and hold p_det at 0.

Reset
REQ-025 On rst low, the block SHALL asynchronously force: state=UNCONF, pattern=0, length=0, history=0, fill=0, p_det=0, armed=0, hit_cnt=0.
REQ-026 Reset mid-stream SHALL discard any partial match; after reset, the pattern SHALL be reloaded before any detection.

Configuration
REQ-027 With macro PROG_PATTERN_DET_COUNT_EN defined, hit_cnt SHALL exist, increment on each p_det pulse, and saturate at 2^CNT_W-1.
REQ-028 The hit counter SHALL NOT be cleared by load.
REQ-029 Without PROG_PATTERN_DET_COUNT_EN, the hit_cnt port and its counter logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-030 Package prog_pattern_det_pkg SHALL hold the state enum (UNCONF, ARMED) and the legal MAX_LEN bounds.
REQ-031 The saturating counter SHALL be the sub-module sat_counter (parameter CNT_W; ports clk, rst, inc, count).

Verification
REQ-032 MAX_LEN=8, OVERLAP=1, pattern 10110 (len 5), stream 10110110110 with in_valid=1 -> p_det pulses after bits 5, 8 and 11; hit_cnt=3.
REQ-033 Same stimulus with OVERLAP=0 -> p_det pulses after bits 5 and 11 only; hit_cnt=2.
REQ-034 Pattern 10110, stream 10110 with in_valid=0 for 3 cycles between bits 3 and 4 -> exactly one p_det pulse, one cycle after bit 5.
REQ-035 Load len_in=8 with pat 8'hA5, stream 10100101 -> one pulse; load len_in=0 -> armed=0, stream 10110 produces no pulse.
REQ-036 Pattern 10110, stream 1011, then assert rst, reload, then send 0 -> no pulse; a full 10110 afterwards -> one pulse.
REQ-037 CNT_W=4 under PROG_PATTERN_DET_COUNT_EN, 17 matches -> hit_cnt=15; load mid-stream -> hit_cnt holds and no pulse occurs on the cycle after the load.

Source files
------------

// File: rtl/prog_pattern_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
// Optional hit counter is enabled by defining PROG_PATTERN_DET_COUNT_EN.
package prog_pattern_det_pkg;

  // Detector FSM: UNCONF until a legal pattern is loaded, then ARMED.
  typedef enum logic [0:0] {
    UNCONF = 1'b0,
    ARMED  = 1'b1
  } state_e;

  // Legal range for the MAX_LEN parameter.
  localparam int MAX_LEN_LO = 2;
  localparam int MAX_LEN_HI = 32;

  // A loaded length is usable when it is non-zero and fits the pattern register.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 32'd1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/prog_pattern_det_if.sv
// Configuration, serial data and status bundle of the pattern detector.
// hit_cnt exists only when PROG_PATTERN_DET_COUNT_EN is defined.
interface prog_pattern_det_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               load;
  logic [MAX_LEN-1:0] pat_in;
  logic [LEN_W-1:0]   len_in;
  logic               in_valid;
  logic               in_bit;
  logic               p_det;
  logic               armed;
`ifdef PROG_PATTERN_DET_COUNT_EN
  logic [CNT_W-1:0]   hit_cnt;
`endif

  // Driver side: loads patterns, streams bits, observes detections.
  modport master (
    output load, pat_in, len_in, in_valid, in_bit,
    input  p_det, armed
`ifdef PROG_PATTERN_DET_COUNT_EN
    , input hit_cnt
`endif
  );

  // Detector side.
  modport slave (
    input  load, pat_in, len_in, in_valid, in_bit,
    output p_det, armed
`ifdef PROG_PATTERN_DET_COUNT_EN
    , output hit_cnt
`endif
  );

endinterface

// File: rtl/prog_pattern_det_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count events until the all-ones value, then hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

// File: rtl/prog_pattern_det.sv
// Programmable serial pattern detector with overlapping or non-overlapping
// matching. Define PROG_PATTERN_DET_COUNT_EN to add the saturating hit counter.
module prog_pattern_det
  import prog_pattern_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  prog_pattern_det_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e             r_state, w_state_nxt;
  logic [MAX_LEN-1:0] r_pat, w_pat_nxt;
  logic [MAX_LEN-1:0] r_hist, w_hist_nxt;
  logic [MAX_LEN-1:0] w_hist_sh, w_mask;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [LEN_W-1:0]   r_fill, w_fill_nxt, w_fill_inc;
  logic               r_p_det, w_p_det_nxt;
  logic               w_len_legal, w_match;

  // Candidate history/fill after taking in_bit, and the match decision on them.
  always_comb begin
    w_hist_sh = {r_hist[MAX_LEN-2:0], bus.in_bit};
    if (r_fill == MAX_LEN_L) begin
      w_fill_inc = r_fill;
    end else begin
      w_fill_inc = r_fill + {{(LEN_W-1){1'b0}}, 1'b1};
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
    w_len_legal = len_legal(32'(bus.len_in), MAX_LEN);
    w_match     = (r_state == ARMED) && bus.in_valid && !bus.load
                  && (((w_hist_sh ^ r_pat) & w_mask) == {MAX_LEN{1'b0}})
                  && (w_fill_inc >= r_len);
  end

  // Next state: load has priority and never produces a detection.
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_len_nxt   = r_len;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_p_det_nxt = 1'b0;
    if (bus.load) begin
      w_hist_nxt = {MAX_LEN{1'b0}};
      w_fill_nxt = {LEN_W{1'b0}};
      if (w_len_legal) begin
        w_state_nxt = ARMED;
        w_pat_nxt   = bus.pat_in;
        w_len_nxt   = bus.len_in;
      end else begin
        w_state_nxt = UNCONF;
      end
    end else begin
      case (r_state)
        ARMED: begin
          if (bus.in_valid) begin
            w_hist_nxt  = w_hist_sh;
            w_p_det_nxt = w_match;
            // Non-overlapping mode restarts the fill so no bit is reused.
            if (w_match && (OVERLAP == 0)) begin
              w_fill_nxt = {LEN_W{1'b0}};
            end else begin
              w_fill_nxt = w_fill_inc;
            end
          end else begin
            w_p_det_nxt = 1'b0;
          end
        end
        UNCONF: begin
          w_p_det_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = UNCONF;
        end
      endcase
    end
  end

  // State and datapath registers; reset wipes any configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= UNCONF;
      r_pat   <= {MAX_LEN{1'b0}};
      r_len   <= {LEN_W{1'b0}};
      r_hist  <= {MAX_LEN{1'b0}};
      r_fill  <= {LEN_W{1'b0}};
      r_p_det <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_len   <= w_len_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_p_det <= w_p_det_nxt;
    end
  end

  assign bus.p_det = r_p_det;
  assign bus.armed = (r_state == ARMED);

`ifdef PROG_PATTERN_DET_COUNT_EN
  logic [CNT_W-1:0] w_hit_cnt;

  // Detection counter survives pattern reloads; only reset clears it.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (r_p_det),
    .count (w_hit_cnt)
  );

  assign bus.hit_cnt = w_hit_cnt;
`else
`endif

endmodule

// File: tb/tb_prog_pattern_det.sv
// Directed testbench for prog_pattern_det: one overlapping and one
// non-overlapping instance driven with identical stimulus.
module tb_prog_pattern_det;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  prog_pattern_det_if #(.MAX_LEN(8), .CNT_W(4)) if_ov ();
  prog_pattern_det_if #(.MAX_LEN(8), .CNT_W(4)) if_no ();

  prog_pattern_det #(.MAX_LEN(8), .OVERLAP(1), .CNT_W(4)) u_dut_ov (
    .clk (clk),
    .rst (rst),
    .bus (if_ov)
  );

  prog_pattern_det #(.MAX_LEN(8), .OVERLAP(0), .CNT_W(4)) u_dut_no (
    .clk (clk),
    .rst (rst),
    .bus (if_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic v, input logic b);
    if_ov.load = ld; if_ov.pat_in = pat; if_ov.len_in = len; if_ov.in_valid = v; if_ov.in_bit = b;
    if_no.load = ld; if_no.pat_in = pat; if_no.len_in = len; if_no.in_valid = v; if_no.in_bit = b;
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                      input logic v, input logic b);
    @(negedge clk);
    drive(ld, pat, len, v, b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    check_eq({tag, "_armed_ov"}, 64'(if_ov.armed), 64'd0);
    check_eq({tag, "_armed_no"}, 64'(if_no.armed), 64'd0);
    check_eq({tag, "_pdet_ov"}, 64'(if_ov.p_det), 64'd0);
    check_eq({tag, "_pdet_no"}, 64'(if_no.p_det), 64'd0);
`ifdef PROG_PATTERN_DET_COUNT_EN
    check_eq({tag, "_cnt_ov"}, 64'(if_ov.hit_cnt), 64'd0);
    check_eq({tag, "_cnt_no"}, 64'(if_no.hit_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Load a pattern; the cycle after a load must never carry a detection.
  task automatic load_pat(input string tag, input logic [7:0] pat, input logic [3:0] len,
                          input logic v, input logic b, input logic exp_armed);
    step(1'b1, pat, len, v, b);
    check_eq({tag, "_armed_ov"}, 64'(if_ov.armed), 64'(exp_armed));
    check_eq({tag, "_armed_no"}, 64'(if_no.armed), 64'(exp_armed));
    check_eq({tag, "_pdet_ov"}, 64'(if_ov.p_det), 64'd0);
    check_eq({tag, "_pdet_no"}, 64'(if_no.p_det), 64'd0);
  endtask

  // Stream '0'/'1' as valid bits and '-' as idle; bit i of a mask = p_det after step i.
  task automatic run_stream(input string s, output logic [63:0] m_ov, output logic [63:0] m_no);
    byte c;
    m_ov = 64'd0;
    m_no = 64'd0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "-") step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
      else          step(1'b0, 8'h00, 4'd0, 1'b1, (c == "1"));
      m_ov[i] = if_ov.p_det;
      m_no[i] = if_no.p_det;
    end
  endtask

  initial begin
    logic [63:0] m_ov, m_no;
    int          hits_ov, hits_no;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

    // Reset state, then overlapping vs non-overlapping on 10110110110.
    do_reset("rst0");
    load_pat("ld10110", 8'h16, 4'd5, 1'b0, 1'b0, 1'b1);
    run_stream("10110110110", m_ov, m_no);
    check_eq("ovl_pulses", m_ov, 64'h490);
    check_eq("novl_pulses", m_no, 64'h410);
    run_stream("-", m_ov, m_no);
    check_eq("idle_ov", m_ov, 64'd0);
    check_eq("idle_no", m_no, 64'd0);
`ifdef PROG_PATTERN_DET_COUNT_EN
    check_eq("cnt3_ov", 64'(if_ov.hit_cnt), 64'd3);
    check_eq("cnt2_no", 64'(if_no.hit_cnt), 64'd2);
`endif

    // Gaps in in_valid hold the history: 101 --- 10 gives one pulse at the end.
    load_pat("ld_gap", 8'h16, 4'd5, 1'b0, 1'b0, 1'b1);
    run_stream("101---10", m_ov, m_no);
    check_eq("gap_ov", m_ov, 64'h80);
    check_eq("gap_no", m_no, 64'h80);

    // Full-length pattern A5, then illegal lengths disarm.
    load_pat("ld_a5", 8'hA5, 4'd8, 1'b0, 1'b0, 1'b1);
    run_stream("10100101", m_ov, m_no);
    check_eq("len8_ov", m_ov, 64'h80);
    check_eq("len8_no", m_no, 64'h80);
    load_pat("ld_len0", 8'h16, 4'd0, 1'b0, 1'b0, 1'b0);
    run_stream("10110", m_ov, m_no);
    check_eq("len0_ov", m_ov, 64'd0);
    check_eq("len0_no", m_no, 64'd0);
    load_pat("ld_rearm", 8'h16, 4'd5, 1'b0, 1'b0, 1'b1);
    load_pat("ld_len9", 8'h16, 4'd9, 1'b0, 1'b0, 1'b0);
    run_stream("10110", m_ov, m_no);
    check_eq("len9_ov", m_ov, 64'd0);
    check_eq("len9_no", m_no, 64'd0);

    // Reset mid-stream discards the partial match and the pattern.
    load_pat("ld_pre", 8'h16, 4'd5, 1'b0, 1'b0, 1'b1);
    run_stream("1011", m_ov, m_no);
    do_reset("rst_mid");
    run_stream("10110", m_ov, m_no);
    check_eq("unconf_ov", m_ov, 64'd0);
    check_eq("unconf_no", m_no, 64'd0);
    load_pat("ld_post", 8'h16, 4'd5, 1'b0, 1'b0, 1'b1);
    run_stream("0", m_ov, m_no);
    check_eq("post0_ov", m_ov, 64'd0);
    check_eq("post0_no", m_no, 64'd0);
    run_stream("10110", m_ov, m_no);
    check_eq("post_ov", m_ov, 64'h10);
    check_eq("post_no", m_no, 64'h10);

    // Seventeen matches saturate the 4-bit counter; a load mid-stream is inert.
    do_reset("rst_sat");
    load_pat("ld_sat", 8'h16, 4'd5, 1'b0, 1'b0, 1'b1);
    hits_ov = 0;
    hits_no = 0;
    for (int k = 0; k < 17; k++) begin
      run_stream("10110", m_ov, m_no);
      if (m_ov == 64'h10) hits_ov++;
      if (m_no == 64'h10) hits_no++;
    end
    check_eq("hits17_ov", 64'(hits_ov), 64'd17);
    check_eq("hits17_no", 64'(hits_no), 64'd17);
    run_stream("-", m_ov, m_no);
`ifdef PROG_PATTERN_DET_COUNT_EN
    check_eq("sat_ov", 64'(if_ov.hit_cnt), 64'd15);
    check_eq("sat_no", 64'(if_no.hit_cnt), 64'd15);
`endif
    run_stream("1011", m_ov, m_no);
    load_pat("ld_mid", 8'h16, 4'd5, 1'b1, 1'b0, 1'b1);
    run_stream("0-", m_ov, m_no);
    check_eq("after_ld_ov", m_ov, 64'd0);
    check_eq("after_ld_no", m_no, 64'd0);
`ifdef PROG_PATTERN_DET_COUNT_EN
    check_eq("hold_ov", 64'(if_ov.hit_cnt), 64'd15);
    check_eq("hold_no", 64'(if_no.hit_cnt), 64'd15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
